// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes board/JTAG reset requests and PLL lock, debounces
// request release, then releases core and peripheral resets in a timed sequence.
module reset_sequencer #(
    parameter int unsigned DebounceCycles = 16,
    parameter int unsigned StretchCycles  = 64,
    parameter int unsigned PeriphDelay    = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ext_rst_ni,
    input  logic       jtag_srst_ni,
    input  logic       pll_locked_i,
    output logic       rst_sys_no,
    output logic       rst_periph_no,
    output logic [1:0] state_o,
    output logic [2:0] cause_o
);

    localparam logic [1:0] HOLD      = 2'd0;
    localparam logic [1:0] WAIT_LOCK = 2'd1;
    localparam logic [1:0] STRETCH   = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam int unsigned DEB_W = $clog2(DebounceCycles) + 1;
    localparam int unsigned STR_W = $clog2(StretchCycles) + 1;
    localparam int unsigned PER_W = $clog2(PeriphDelay) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DebounceCycles - 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(StretchCycles - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PeriphDelay - 1);

    // Bit order in both stages: [0] ext, [1] jtag, [2] pll lock.
    logic [2:0] sync_q1;
    logic [2:0] sync_q2;
    logic       ext_s;
    logic       jtag_s;
    logic       locked_s;
    logic       req_s;

    logic             req_deb;
    logic [DEB_W-1:0] deb_cnt;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [STR_W-1:0] stretch_cnt;
    logic [STR_W-1:0] stretch_next;
    logic [PER_W-1:0] periph_cnt;
    logic [2:0]       cause;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {pll_locked_i, jtag_srst_ni, ext_rst_ni};
            sync_q2 <= sync_q1;
        end
    end

    assign ext_s    = sync_q2[0];
    assign jtag_s   = sync_q2[1];
    assign locked_s = sync_q2[2];
    assign req_s    = ~ext_s | ~jtag_s;

    // Requests assert immediately; release needs DebounceCycles clean cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_cnt <= '0;
            req_deb <= 1'b1;
        end else if (req_s) begin
            deb_cnt <= '0;
            req_deb <= 1'b1;
        end else if (deb_cnt == DEB_LAST) begin
            req_deb <= 1'b0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        stretch_next = stretch_cnt;
        if (req_deb) begin
            state_next = HOLD;
        end else begin
            case (state)
                HOLD: state_next = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next   = STRETCH;
                        stretch_next = '0;
                    end
                end
                STRETCH: begin
                    if (!locked_s) begin
                        state_next = WAIT_LOCK;
                    end else if (stretch_cnt == STR_LAST) begin
                        state_next = RUN;
                    end else begin
                        stretch_next = stretch_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_next = WAIT_LOCK;
                    end
                end
                default: state_next = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= HOLD;
            stretch_cnt <= '0;
        end else begin
            state       <= state_next;
            stretch_cnt <= stretch_next;
        end
    end

    // Both reset outputs fall on the edge that leaves RUN; the peripheral
    // counter saturates so it cannot wrap during a long RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_sys_no    <= 1'b0;
            rst_periph_no <= 1'b0;
            periph_cnt    <= '0;
        end else begin
            rst_sys_no <= (state_next == RUN);
            if (state != RUN && state_next == RUN) begin
                periph_cnt <= '0;
            end else if (state == RUN && periph_cnt != PER_LAST) begin
                periph_cnt <= periph_cnt + 1'b1;
            end
            if (state_next != RUN) begin
                rst_periph_no <= 1'b0;
            end else if (state == RUN && periph_cnt == PER_LAST) begin
                rst_periph_no <= 1'b1;
            end
        end
    end

    // Lock loss only counts when no request wins the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause <= '0;
        end else begin
            cause <= cause | {
                (!req_deb && (state == STRETCH || state == RUN) && !locked_s),
                (req_deb && state != HOLD && !jtag_s),
                (req_deb && state != HOLD && !ext_s)
            };
        end
    end

    assign state_o = state;
    assign cause_o = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios plus randomized input traffic,
// compared every cycle against a behavioural model of the release sequence.
module tb_reset_sequencer;

    localparam int D = 4;
    localparam int S = 8;
    localparam int P = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       ext_rst_ni;
    logic       jtag_srst_ni;
    logic       pll_locked_i;
    logic       rst_sys_no;
    logic       rst_periph_no;
    logic [1:0] state_o;
    logic [2:0] cause_o;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Model: synchronizer stages, length of the current clean-request run,
    // phase (0..3), age within STRETCH and RUN, and sticky cause bits.
    int       m_q1_ext, m_q1_jtag, m_q1_lock;
    int       m_ext_s, m_jtag_s, m_lock_s;
    int       m_clean, m_req_deb, m_state, m_stretch_age, m_run_age;
    logic [2:0] m_cause;

    reset_sequencer #(
        .DebounceCycles(D),
        .StretchCycles (S),
        .PeriphDelay   (P)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ext_rst_ni   (ext_rst_ni),
        .jtag_srst_ni (jtag_srst_ni),
        .pll_locked_i (pll_locked_i),
        .rst_sys_no   (rst_sys_no),
        .rst_periph_no(rst_periph_no),
        .state_o      (state_o),
        .cause_o      (cause_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic modelEdge();
        int req_s;
        int nxt;
        if (rst_i) begin
            m_q1_ext = 0; m_q1_jtag = 0; m_q1_lock = 0;
            m_ext_s = 0; m_jtag_s = 0; m_lock_s = 0;
            m_clean = 0; m_req_deb = 1; m_state = 0;
            m_stretch_age = 0; m_run_age = 0; m_cause = 3'b000;
            return;
        end
        req_s = (m_ext_s == 0 || m_jtag_s == 0) ? 1 : 0;
        nxt = m_state;
        if (m_req_deb == 1) begin
            if (m_state != 0) begin
                if (m_ext_s == 0)  m_cause[0] = 1'b1;
                if (m_jtag_s == 0) m_cause[1] = 1'b1;
            end
            nxt = 0;
        end else if (m_state == 0) begin
            nxt = 1;
        end else if (m_state == 1) begin
            if (m_lock_s == 1) begin
                nxt = 2;
                m_stretch_age = 0;
            end
        end else if (m_lock_s == 0) begin
            nxt = 1;
            m_cause[2] = 1'b1;
        end else if (m_state == 2) begin
            if (m_stretch_age == S - 1) begin
                nxt = 3;
                m_run_age = 0;
            end else begin
                m_stretch_age++;
            end
        end else begin
            m_run_age++;
        end
        m_state = nxt;
        if (req_s == 1)          m_req_deb = 1;
        else if (m_clean >= D-1) m_req_deb = 0;
        m_clean = (req_s == 1) ? 0 : m_clean + 1;
        m_ext_s  = m_q1_ext;  m_q1_ext  = int'(ext_rst_ni);
        m_jtag_s = m_q1_jtag; m_q1_jtag = int'(jtag_srst_ni);
        m_lock_s = m_q1_lock; m_q1_lock = int'(pll_locked_i);
    endtask

    task automatic checkOutput();
        logic exp_sys;
        logic exp_periph;
        exp_sys    = (m_state == 3);
        exp_periph = (m_state == 3 && m_run_age >= P);
        checkValue("state", {2'b00, state_o}, 4'(m_state));
        checkValue("rst_sys_no", {3'b000, rst_sys_no}, {3'b000, exp_sys});
        checkValue("rst_periph_no", {3'b000, rst_periph_no}, {3'b000, exp_periph});
        checkValue("cause", {1'b0, cause_o}, {1'b0, m_cause});
        checkValue("periph_without_sys", {3'b000, rst_periph_no & ~rst_sys_no}, 4'h0);
    endtask

    task automatic applyStimulus(input logic ext, input logic jtag, input logic lock,
                                 input logic rst, input int n);
        ext_rst_ni   = ext;
        jtag_srst_ni = jtag;
        pll_locked_i = lock;
        rst_i        = rst;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            modelEdge();
            #1;
            cycle++;
            checkOutput();
        end
    endtask

    initial begin
        int sys_edge;
        int periph_edge;
        logic e, j, l, r;
        int n;

        // Reset state, then clean power-up with all inputs high.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3);
        checkValue("reset_sys", {3'b000, rst_sys_no}, 4'h0);
        checkValue("reset_cause", {1'b0, cause_o}, 4'h0);
        sys_edge    = -1;
        periph_edge = -1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
            if (sys_edge < 0 && rst_sys_no === 1'b1)       sys_edge = i;
            if (periph_edge < 0 && rst_periph_no === 1'b1) periph_edge = i;
        end
        checkValue("powerup_state", {2'b00, state_o}, 4'd3);
        checkValue("periph_lag", 4'(periph_edge - sys_edge), 4'(P));

        // Request and lock drop meeting on the same FSM edge: no lock-loss cause.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6);
        checkValue("combo_state", {2'b00, state_o}, 4'd0);
        checkValue("combo_cause", {1'b0, cause_o}, 4'b0011);

        // Button bounce while leaving reset: no release until 4 clean cycles.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2);
        for (int i = 0; i < 18; i++) begin
            applyStimulus((i % 3) != 0, 1'b1, 1'b1, 1'b0, 1);
        end
        checkValue("bounce_hold_sys", {3'b000, rst_sys_no}, 4'h0);
        checkValue("bounce_hold_state", {2'b00, state_o}, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 30);
        checkValue("bounce_run", {2'b00, state_o}, 4'd3);

        // Lock loss in RUN: outputs drop on the third edge after the input falls.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2);
        checkValue("lock_drop_early", {3'b000, rst_sys_no}, 4'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
        checkValue("lock_drop_sys", {3'b000, rst_sys_no}, 4'h0);
        checkValue("lock_drop_state", {2'b00, state_o}, 4'd1);
        checkValue("lock_drop_cause", {1'b0, cause_o}, 4'b0100);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 25);
        checkValue("relock_state", {2'b00, state_o}, 4'd3);
        checkValue("relock_cause", {1'b0, cause_o}, 4'b0100);

        // Reset pulse during STRETCH, then during RUN.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
        checkValue("rst_clears_cause", {1'b0, cause_o}, 4'h0);
        for (int i = 0; i < 40 && state_o !== 2'd2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
        end
        checkValue("reach_stretch", {2'b00, state_o}, 4'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
        checkValue("stretch_rst_state", {2'b00, state_o}, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 30);
        checkValue("rerun_state", {2'b00, state_o}, 4'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
        checkValue("run_rst_sys", {3'b000, rst_sys_no}, 4'h0);
        checkValue("run_rst_periph", {3'b000, rst_periph_no}, 4'h0);
        checkValue("run_rst_cause", {1'b0, cause_o}, 4'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 30);
        checkValue("rerun2_state", {2'b00, state_o}, 4'd3);

        // Randomized traffic, mostly quiet inputs with occasional long holds.
        for (int k = 0; k < 300; k++) begin
            e = ($urandom_range(0, 9) != 0);
            j = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 29) == 0);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 6);
            applyStimulus(e, j, l, r, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
